pair_match_tally: RTL

PAIR_MATCH_TALLY -- requirements
Module: pair_match_tally

---
 rtl/pair_match_pkg.sv | 21 ++
 rtl/pair_and_array.sv | 25 ++
 rtl/pair_match_tally.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pair_match_pkg.sv
// Shared types and index helpers for the pairwise match tally block.
// Pairs are enumerated (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
package pair_match_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int n_pairs(input int n_players);
        return (n_players * (n_players - 1)) / 2;
    endfunction

    // Row i starts after the (n-1)+(n-2)+..+(n-i) pairs of earlier rows.
    function automatic int pair_index(input int i, input int j, input int n_players);
        return i * n_players - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/pair_and_array.sv
// Combinational pairwise AND of every player's choice against every later player.
// Output slice p*N_BITS +: N_BITS belongs to pair index p.
module pair_and_array
    import pair_match_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int N_BITS    = 3,
    localparam int N_PAIRS  = n_pairs(N_PLAYERS)
) (
    input  logic [N_PLAYERS*N_BITS-1:0] choices,
    output logic [N_PAIRS*N_BITS-1:0]   pair_and
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_PLAYERS - 1; gi++) begin : g_row
            for (gj = gi + 1; gj < N_PLAYERS; gj++) begin : g_col
                localparam int P = pair_index(gi, gj, N_PLAYERS);
                assign pair_and[P*N_BITS +: N_BITS] =
                    choices[gi*N_BITS +: N_BITS] & choices[gj*N_BITS +: N_BITS];
            end
        end
    endgenerate

endmodule

// File: rtl/pair_match_tally.sv
// Collects one choice per player per round, compares all pairs, and keeps
// saturating per-pair hit tallies plus a saturating round counter.
module pair_match_tally
    import pair_match_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int N_BITS    = 3,
    parameter int CNT_W     = 4,
    localparam int N_PAIRS  = n_pairs(N_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic [N_PLAYERS-1:0]         play_valid,
    input  logic [N_PLAYERS*N_BITS-1:0]  play_bits,
    output logic [N_PLAYERS-1:0]         submitted,
    output logic                         busy,
    output logic                         done,
    output logic [N_PAIRS*N_BITS-1:0]    match,
    output logic [N_PAIRS-1:0]           pair_hit,
    output logic [N_PAIRS*CNT_W-1:0]     tally,
    output logic [CNT_W-1:0]             rounds
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                        state_reg, state_next;
    logic [N_PLAYERS-1:0]          submitted_reg;
    logic [N_PLAYERS-1:0]          accept;
    logic [N_PLAYERS*N_BITS-1:0]   choices_reg;
    logic [N_PAIRS*N_BITS-1:0]     and_vec;
    logic [N_PAIRS*N_BITS-1:0]     match_reg;
    logic [N_PAIRS-1:0]            hit_vec;
    logic [N_PAIRS-1:0]            hit_reg;
    logic [CNT_W-1:0]              tally_reg [N_PAIRS];
    logic [CNT_W-1:0]              rounds_reg;
    logic                          all_in;
    logic                          compare_exit;

    // Only players that have not yet submitted this round are accepted.
    assign accept       = (state_reg == COLLECT) ? (play_valid & ~submitted_reg) : '0;
    assign all_in       = &(submitted_reg | accept);
    assign compare_exit = (state_reg == COMPARE);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)  state_next = COLLECT;
            COLLECT: if (all_in) state_next = COMPARE;
            COMPARE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            submitted_reg <= '0;
            choices_reg   <= '0;
        end else begin
            if (state_reg == IDLE && start) submitted_reg <= '0;
            else                            submitted_reg <= submitted_reg | accept;
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (accept[i]) choices_reg[i*N_BITS +: N_BITS] <= play_bits[i*N_BITS +: N_BITS];
            end
        end
    end

    pair_and_array #(
        .N_PLAYERS (N_PLAYERS),
        .N_BITS    (N_BITS)
    ) u_pair_and (
        .choices  (choices_reg),
        .pair_and (and_vec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_PAIRS; gi++) begin : g_pair
            assign hit_vec[gi]               = |and_vec[gi*N_BITS +: N_BITS];
            assign tally[gi*CNT_W +: CNT_W]  = tally_reg[gi];
        end
    endgenerate

    // match/pair_hit only move on a COMPARE exit; clear does not touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_reg <= '0;
            hit_reg   <= '0;
        end else if (compare_exit) begin
            match_reg <= and_vec;
            hit_reg   <= hit_vec;
        end
    end

    // clear outranks a coincident increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int p = 0; p < N_PAIRS; p++) tally_reg[p] <= '0;
            rounds_reg <= '0;
        end else if (compare_exit) begin
            for (int p = 0; p < N_PAIRS; p++) begin
                if (hit_vec[p] && tally_reg[p] != CNT_MAX)
                    tally_reg[p] <= tally_reg[p] + CNT_W'(1);
            end
            if (rounds_reg != CNT_MAX) rounds_reg <= rounds_reg + CNT_W'(1);
        end
    end

    assign submitted = submitted_reg;
    assign busy      = (state_reg == COLLECT) || (state_reg == COMPARE);
    assign done      = (state_reg == DONE);
    assign match     = match_reg;
    assign pair_hit  = hit_reg;
    assign rounds    = rounds_reg;

endmodule
